// File: rtl/ml_accel_pkg.sv
// Shared definitions for the ML accelerator sequencer: default parameters,
// state encoding and the GIN packet width helper.
package ml_accel_pkg;

  localparam int DEF_BITWIDTH     = 16;
  localparam int DEF_PE_Y_SIZE    = 3;
  localparam int DEF_PE_X_SIZE    = 3;
  localparam int DEF_TAG_LENGTH   = 4;
  localparam int DEF_DRAIN_CYCLES = 5;
  localparam int CFG_ADDR_W       = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PROG    = 3'd1,
    S_LOAD    = 3'd2,
    S_DRAIN   = 3'd3,
    S_CAPTURE = 3'd4,
    S_CLEAR   = 3'd5
  } seq_state_e;

  // GIN packet is {row tag, col tag, data word}
  function automatic int packet_width(input int tag_length, input int bitwidth);
    return 2 * tag_length + bitwidth;
  endfunction

endpackage

// File: rtl/ml_accel_sequencer_scan_tag_table.sv
// Scan-chain tag table: small register file, one write port, one
// combinational read port. Out-of-range writes are dropped, reads return 0.
module scan_tag_table
  import ml_accel_pkg::*;
#(
  parameter int DEPTH = 12,
  parameter int WIDTH = DEF_TAG_LENGTH
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  we,
  input  logic [CFG_ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [CFG_ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Table storage, cleared on reset
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/ml_accel_sequencer.sv
// ML accelerator job sequencer: optional scan-chain programming, ifmap /
// filter streaming onto the GIN buses, drain, ofmap capture and PE clear.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; tag-table writes accepted here only
// PROG    | drive tag entries in index order, 2 cycles each, program_en=1
// LOAD    | PE_Y_SIZE passes of PE_X_SIZE+PE_Y_SIZE-1 handshaked beats
// DRAIN   | wait DRAIN_CYCLES for the array to settle
// CAPTURE | latch ofmap into result, pulse done
// CLEAR   | pulse pe_reset low, return to IDLE
module ml_accel_sequencer
  import ml_accel_pkg::*;
#(
  parameter int BITWIDTH     = DEF_BITWIDTH,
  parameter int PE_Y_SIZE    = DEF_PE_Y_SIZE,
  parameter int PE_X_SIZE    = DEF_PE_X_SIZE,
  parameter int TAG_LENGTH   = DEF_TAG_LENGTH,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic                                         clk,
  input  logic                                         rstb,
  input  logic                                         start,
  input  logic                                         do_program,
  input  logic                                         cfg_we,
  input  logic                                         cfg_sel,
  input  logic [CFG_ADDR_W-1:0]                        cfg_addr,
  input  logic [TAG_LENGTH-1:0]                        cfg_data,
  input  logic                                         ifm_valid,
  input  logic [BITWIDTH-1:0]                          ifm_data,
  output logic                                         ifm_ready,
  input  logic                                         flt_valid,
  input  logic [BITWIDTH-1:0]                          flt_data,
  output logic                                         flt_ready,
  output logic                                         program_en,
  output logic [TAG_LENGTH-1:0]                        scan_chain_input_ifmap,
  output logic [TAG_LENGTH-1:0]                        scan_chain_input_filter,
  output logic                                         gin_enable_ifmap,
  output logic                                         gin_enable_filter,
  output logic [packet_width(TAG_LENGTH, BITWIDTH)-1:0] data_packet_ifmap,
  output logic [packet_width(TAG_LENGTH, BITWIDTH)-1:0] data_packet_filter,
  output logic                                         pe_reset,
  input  logic [BITWIDTH*PE_X_SIZE-1:0]                ofmap,
  output logic [BITWIDTH*PE_X_SIZE-1:0]                result,
  output logic                                         busy,
  output logic                                         done
);

  localparam int NUM_TAGS = PE_Y_SIZE + PE_Y_SIZE * PE_X_SIZE;
  localparam int BEATS    = PE_X_SIZE + PE_Y_SIZE - 1;
  localparam int BEAT_W   = $clog2(BEATS + 1);
  localparam int PASS_W   = $clog2(PE_Y_SIZE + 1);
  localparam int PROG_W   = $clog2(2 * NUM_TAGS + 1);
  localparam int DRAIN_W  = $clog2(DRAIN_CYCLES + 1);

  seq_state_e            state;
  logic [BEAT_W-1:0]     beat;
  logic [PASS_W-1:0]     pass;
  logic [PROG_W-1:0]     prog_cnt;
  logic [PROG_W-1:0]     prog_next;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic                  flt_beat;
  logic                  fire;
  logic                  cfg_ok;
  logic [CFG_ADDR_W-1:0] tab_raddr;
  logic [TAG_LENGTH-1:0] rd_ifmap;
  logic [TAG_LENGTH-1:0] rd_filter;

  assign cfg_ok    = cfg_we && (state == S_IDLE);
  assign prog_next = prog_cnt + 1'b1;
  // Read one entry ahead so the registered scan outputs line up with prog_cnt
  assign tab_raddr = (state == S_PROG) ? CFG_ADDR_W'(prog_next >> 1) : '0;

  // Only the first PE_Y_SIZE beats of a pass carry a filter word
  assign flt_beat  = (int'(beat) < PE_Y_SIZE);
  assign fire      = (state == S_LOAD) && ifm_valid && (!flt_beat || flt_valid);
  assign ifm_ready = fire;
  assign flt_ready = fire && flt_beat;
  assign busy      = (state != S_IDLE);

  scan_tag_table #(.DEPTH(NUM_TAGS), .WIDTH(TAG_LENGTH)) u_tab_ifmap (
    .clk   (clk),
    .rstb  (rstb),
    .we    (cfg_ok && !cfg_sel),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (tab_raddr),
    .rdata (rd_ifmap)
  );

  scan_tag_table #(.DEPTH(NUM_TAGS), .WIDTH(TAG_LENGTH)) u_tab_filter (
    .clk   (clk),
    .rstb  (rstb),
    .we    (cfg_ok && cfg_sel),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (tab_raddr),
    .rdata (rd_filter)
  );

  // Job sequencing FSM with registered outputs
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state                   <= S_IDLE;
      beat                    <= '0;
      pass                    <= '0;
      prog_cnt                <= '0;
      drain_cnt               <= '0;
      program_en              <= 1'b0;
      scan_chain_input_ifmap  <= '0;
      scan_chain_input_filter <= '0;
      gin_enable_ifmap        <= 1'b0;
      gin_enable_filter       <= 1'b0;
      data_packet_ifmap       <= '0;
      data_packet_filter      <= '0;
      pe_reset                <= 1'b0;
      done                    <= 1'b0;
      result                  <= '0;
    end else begin
      gin_enable_ifmap  <= 1'b0;
      gin_enable_filter <= 1'b0;
      done              <= 1'b0;
      pe_reset          <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (do_program) begin
              state                   <= S_PROG;
              program_en              <= 1'b1;
              prog_cnt                <= '0;
              scan_chain_input_ifmap  <= rd_ifmap;
              scan_chain_input_filter <= rd_filter;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_PROG: begin
          if (prog_cnt == PROG_W'(2 * NUM_TAGS - 1)) begin
            state                   <= S_LOAD;
            program_en              <= 1'b0;
            prog_cnt                <= '0;
            scan_chain_input_ifmap  <= '0;
            scan_chain_input_filter <= '0;
          end else begin
            prog_cnt                <= prog_next;
            scan_chain_input_ifmap  <= rd_ifmap;
            scan_chain_input_filter <= rd_filter;
          end
        end
        S_LOAD: begin
          if (fire) begin
            gin_enable_ifmap  <= 1'b1;
            data_packet_ifmap <= {{TAG_LENGTH{1'b0}}, TAG_LENGTH'(beat), ifm_data};
            if (flt_beat) begin
              gin_enable_filter  <= 1'b1;
              data_packet_filter <= {{TAG_LENGTH{1'b0}}, TAG_LENGTH'(pass), flt_data};
            end
            if (beat == BEAT_W'(BEATS - 1)) begin
              beat <= '0;
              if (pass == PASS_W'(PE_Y_SIZE - 1)) begin
                pass      <= '0;
                state     <= S_DRAIN;
                drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
              end else begin
                pass <= pass + 1'b1;
              end
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) state <= S_CAPTURE;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        S_CAPTURE: begin
          result <= ofmap;
          done   <= 1'b1;
          state  <= S_CLEAR;
        end
        S_CLEAR: begin
          pe_reset <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
